// File: rtl/rpt_hw_pkg.sv
// Shared types and helpers for the on-chip report/event logger.
// Encodings of report type, severity and action match the host-side report facility.
package rpt_hw_pkg;

    typedef enum logic [1:0] {
        RPT_INFO    = 2'd0,
        RPT_WARNING = 2'd1,
        RPT_ERROR   = 2'd2,
        RPT_FATAL   = 2'd3
    } report_t;

    typedef enum logic [1:0] {
        SEV_LOW    = 2'd0,
        SEV_MEDIUM = 2'd1,
        SEV_HIGH   = 2'd2,
        SEV_TOP    = 2'd3
    } severity_t;

    // Code 3 is reserved and behaves exactly like LOG.
    typedef enum logic [1:0] {
        ACT_LOG  = 2'd0,
        ACT_STOP = 2'd1,
        ACT_EXIT = 2'd2,
        ACT_RSVD = 2'd3
    } action_t;

    // Decoded control fields of the event currently granted by the arbiter.
    typedef struct packed {
        report_t   typ;
        severity_t sev;
        action_t   act;
    } rpt_rec_t;

    // Increment that holds at max_val instead of wrapping (counters are <= 32 bits).
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
        logic [31:0] res;
        res = (val >= max_val) ? max_val : val + 32'd1;
        return res;
    endfunction

endpackage

// File: rtl/rpt_rr_arb.sv
// Round-robin arbiter over NCH requesters. The grant is combinational from req;
// the pointer moves one past the granted channel and holds when nothing is granted.
module rpt_rr_arb #(
    parameter int NCH = 4,
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [NCH-1:0]   req,
    input  logic             en,
    output logic [NCH-1:0]   grant,
    output logic             gnt_vld,
    output logic [IDX_W-1:0] gnt_idx
);

    logic [IDX_W-1:0] ptr_r;
    logic [IDX_W:0]   cand_s;
    logic [IDX_W-1:0] idx_s;
    logic             take_s;

    // Scan from the pointer upward with wrap-around and take the first requester.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand_s  = '0;
        idx_s   = '0;
        take_s  = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            cand_s  = {1'b0, ptr_r} + (IDX_W+1)'(i);
            idx_s   = (cand_s >= (IDX_W+1)'(NCH)) ? IDX_W'(cand_s - (IDX_W+1)'(NCH)) : IDX_W'(cand_s);
            take_s  = en & ~gnt_vld & req[idx_s];
            gnt_idx = take_s ? idx_s : gnt_idx;
            gnt_vld = gnt_vld | take_s;
        end
        grant = gnt_vld ? (NCH'(1) << gnt_idx) : '0;
    end

    // Advance the pointer past the granted channel; hold it when idle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_r <= '0;
        end else if (gnt_vld) begin
            ptr_r <= (gnt_idx == IDX_W'(NCH - 1)) ? '0 : gnt_idx + IDX_W'(1);
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/rpt_event_logger.sv
// In-silicon report logger: round-robin collection of events from NCH sources,
// per-type saturating counters, severity filter, record FIFO with drop accounting
// and sticky STOP/EXIT flags. Optional feature macro: RPT_TIMESTAMP_EN adds a
// free-running timestamp to every record and the rd_time port.
module rpt_event_logger
    import rpt_hw_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int MSG_W = 16,
    parameter int DEPTH = 8,
    parameter int CNT_W = 16,
    parameter int TS_W  = 32,
    localparam int SRC_W = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NCH-1:0]     ev_valid,
    output logic [NCH-1:0]     ev_ready,
    input  logic [2*NCH-1:0]   ev_type,
    input  logic [2*NCH-1:0]   ev_sev,
    input  logic [2*NCH-1:0]   ev_act,
    input  logic [MSG_W*NCH-1:0] ev_msg,
    input  logic [1:0]         svrt_i,
    input  logic               clr_i,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic [1:0]         rd_type,
    output logic [SRC_W-1:0]   rd_src,
    output logic [MSG_W-1:0]   rd_msg,
`ifdef RPT_TIMESTAMP_EN
    output logic [TS_W-1:0]    rd_time,
`endif
    output logic [CNT_W-1:0]   cnt_info,
    output logic [CNT_W-1:0]   cnt_warn,
    output logic [CNT_W-1:0]   cnt_err,
    output logic [CNT_W-1:0]   cnt_fatal,
    output logic [CNT_W-1:0]   drop_cnt,
    output logic               stop_o,
    output logic               exit_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [31:0] CNT_MAX32 = 32'({CNT_W{1'b1}});

    typedef struct packed {
        report_t          typ;
        logic [SRC_W-1:0] src;
        logic [MSG_W-1:0] msg;
`ifdef RPT_TIMESTAMP_EN
        logic [TS_W-1:0]  ts;
`endif
    } rec_t;

    // Clear takes effect first, then this cycle's hit is added with saturation.
    function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] cur, input logic clr, input logic hit);
        logic [CNT_W-1:0] base;
        base = clr ? '0 : cur;
        return hit ? CNT_W'(sat_inc(32'(base), CNT_MAX32)) : base;
    endfunction

    logic             acc_s;
    logic [SRC_W-1:0] gnt_idx_s;
    rpt_rec_t         sel_s;
    logic             qual_s;
    logic             pop_s;
    logic             full_s;
    logic             push_s;
    logic             drop_s;

    logic [CNT_W-1:0] cnt_r [4];
    logic [CNT_W-1:0] drop_r;
    logic             stop_r;
    logic             exit_r;

    rec_t             mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] rd_ptr_nx_s;
    logic [PTR_W:0]   fill_r;
    logic [PTR_W:0]   fill_eff_s;
    logic [PTR_W:0]   fill_nx_s;
    rec_t             rec_in_s;
    rec_t             head_nx_s;
    rec_t             head_r;
    logic             rd_valid_r;

    // Once EXIT is latched the arbiter is disabled, so nothing more is accepted.
    rpt_rr_arb #(.NCH(NCH)) u_arb (
        .clk     (clk),
        .rstn    (rstn),
        .req     (ev_valid),
        .en      (~exit_r),
        .grant   (ev_ready),
        .gnt_vld (acc_s),
        .gnt_idx (gnt_idx_s)
    );

`ifdef RPT_TIMESTAMP_EN
    logic [TS_W-1:0] ts_r;

    // Free-running cycle stamp, wraps naturally.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ts_r <= '0;
        end else begin
            ts_r <= ts_r + TS_W'(1);
        end
    end
`endif

    // Decode the granted channel, apply the severity filter and FIFO push/drop decision.
    always_comb begin
        sel_s.typ    = report_t'(ev_type[2*gnt_idx_s +: 2]);
        sel_s.sev    = severity_t'(ev_sev[2*gnt_idx_s +: 2]);
        sel_s.act    = action_t'(ev_act[2*gnt_idx_s +: 2]);
        qual_s       = acc_s && (sel_s.sev >= svrt_i);
        pop_s        = rd_valid_r && rd_ready;
        full_s       = (fill_r == (PTR_W+1)'(DEPTH));
        push_s       = qual_s && (!full_s || pop_s);
        drop_s       = qual_s && !push_s;
        rec_in_s.typ = sel_s.typ;
        rec_in_s.src = gnt_idx_s;
        rec_in_s.msg = ev_msg[MSG_W*gnt_idx_s +: MSG_W];
`ifdef RPT_TIMESTAMP_EN
        rec_in_s.ts  = ts_r;
`endif
    end

    // Next FIFO head: a record pushed into an (effectively) empty FIFO becomes head at once.
    always_comb begin
        rd_ptr_nx_s = pop_s ? rd_ptr_r + PTR_W'(1) : rd_ptr_r;
        fill_eff_s  = fill_r - (PTR_W+1)'(pop_s);
        fill_nx_s   = fill_eff_s + (PTR_W+1)'(push_s);
        if (fill_eff_s == '0) begin
            head_nx_s = push_s ? rec_in_s : '0;
        end else begin
            head_nx_s = mem_r[rd_ptr_nx_s];
        end
    end

    // Type counters, drop counter and sticky flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int t = 0; t < 4; t++) begin
                cnt_r[t] <= '0;
            end
            drop_r <= '0;
            stop_r <= 1'b0;
            exit_r <= 1'b0;
        end else begin
            for (int t = 0; t < 4; t++) begin
                cnt_r[t] <= cnt_step(cnt_r[t], clr_i, acc_s && (sel_s.typ == report_t'(t)));
            end
            drop_r <= cnt_step(drop_r, clr_i, drop_s);
            stop_r <= (stop_r & ~clr_i) | (qual_s && (sel_s.act == ACT_STOP));
            exit_r <= (exit_r & ~clr_i) | (qual_s && (sel_s.act == ACT_EXIT));
        end
    end

    // Record storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= rec_in_s;
        end
    end

    // FIFO pointers, fill level and registered head outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            fill_r     <= '0;
            rd_valid_r <= 1'b0;
            head_r     <= '0;
        end else begin
            wr_ptr_r   <= push_s ? wr_ptr_r + PTR_W'(1) : wr_ptr_r;
            rd_ptr_r   <= rd_ptr_nx_s;
            fill_r     <= fill_nx_s;
            rd_valid_r <= (fill_nx_s != '0);
            head_r     <= head_nx_s;
        end
    end

    assign rd_valid  = rd_valid_r;
    assign rd_type   = head_r.typ;
    assign rd_src    = head_r.src;
    assign rd_msg    = head_r.msg;
`ifdef RPT_TIMESTAMP_EN
    assign rd_time   = head_r.ts;
`endif
    assign cnt_info  = cnt_r[0];
    assign cnt_warn  = cnt_r[1];
    assign cnt_err   = cnt_r[2];
    assign cnt_fatal = cnt_r[3];
    assign drop_cnt  = drop_r;
    assign stop_o    = stop_r;
    assign exit_o    = exit_r;

endmodule

// File: tb/tb_rpt_event_logger.sv
// Directed bench for rpt_event_logger with a behavioural model and record scoreboard.
module tb_rpt_event_logger;

    localparam int NCH   = 4;
    localparam int MSG_W = 16;
    localparam int DEPTH = 8;
    localparam int CNT_W = 4;
    localparam int TS_W  = 32;
    localparam int CMAX  = 15;

    logic             clk = 1'b0;
    logic             rstn;
    logic [NCH-1:0]   ev_valid;
    logic [NCH-1:0]   ev_ready;
    logic [2*NCH-1:0] ev_type;
    logic [2*NCH-1:0] ev_sev;
    logic [2*NCH-1:0] ev_act;
    logic [MSG_W*NCH-1:0] ev_msg;
    logic [1:0]       svrt_i;
    logic             clr_i;
    logic             rd_valid;
    logic             rd_ready;
    logic [1:0]       rd_type;
    logic [1:0]       rd_src;
    logic [MSG_W-1:0] rd_msg;
    logic [TS_W-1:0]  rd_time;
    logic [CNT_W-1:0] cnt_info, cnt_warn, cnt_err, cnt_fatal, drop_cnt;
    logic             stop_o, exit_o;

    typedef struct {
        logic [1:0]  typ;
        logic [1:0]  src;
        logic [15:0] msg;
        logic [31:0] ts;
    } exp_t;

    exp_t sb[$];
    int   m_cnt[4];
    int   m_drop;
    bit   m_stop;
    bit   m_exit;
    int   m_ptr;
    int   tb_cyc;
    int   n_pass;
    int   n_total;
    int   n_fail;

    rpt_event_logger #(
        .NCH(NCH), .MSG_W(MSG_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .TS_W(TS_W)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .ev_valid  (ev_valid),
        .ev_ready  (ev_ready),
        .ev_type   (ev_type),
        .ev_sev    (ev_sev),
        .ev_act    (ev_act),
        .ev_msg    (ev_msg),
        .svrt_i    (svrt_i),
        .clr_i     (clr_i),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_type   (rd_type),
        .rd_src    (rd_src),
        .rd_msg    (rd_msg),
`ifdef RPT_TIMESTAMP_EN
        .rd_time   (rd_time),
`endif
        .cnt_info  (cnt_info),
        .cnt_warn  (cnt_warn),
        .cnt_err   (cnt_err),
        .cnt_fatal (cnt_fatal),
        .drop_cnt  (drop_cnt),
        .stop_o    (stop_o),
        .exit_o    (exit_o)
    );

`ifndef RPT_TIMESTAMP_EN
    assign rd_time = '0;
`endif

    always #5 clk = ~clk;

    // Edges since reset release: equals the timestamp the design should carry.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) tb_cyc <= 0;
        else       tb_cyc <= tb_cyc + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) m_cnt[k] = 0;
        m_drop = 0;
        m_stop = 1'b0;
        m_exit = 1'b0;
        m_ptr  = 0;
        sb.delete();
    endtask

    task automatic check_all();
        chk("cnt_info", cnt_info, m_cnt[0]);
        chk("cnt_warn", cnt_warn, m_cnt[1]);
        chk("cnt_err", cnt_err, m_cnt[2]);
        chk("cnt_fatal", cnt_fatal, m_cnt[3]);
        chk("drop_cnt", drop_cnt, m_drop);
        chk("stop_o", stop_o, m_stop);
        chk("exit_o", exit_o, m_exit);
        chk("rd_valid", rd_valid, sb.size() != 0);
        if (sb.size() != 0) begin
            chk("head_type", rd_type, sb[0].typ);
            chk("head_src", rd_src, sb[0].src);
            chk("head_msg", rd_msg, sb[0].msg);
        end else begin
            chk("idle_msg", rd_msg, 16'h0);
        end
    endtask

    // One clock: called at a falling edge with inputs set; checks grant and pops,
    // advances the model, then checks outputs at the next falling edge.
    task automatic step();
        int         g;
        int         c;
        logic [3:0] eg;
        logic [1:0] t, s, a;
        exp_t       e;
        #1;
        if ((sb.size() != 0) && rd_ready) begin
            e = sb.pop_front();
            chk("sb_type", rd_type, e.typ);
            chk("sb_src", rd_src, e.src);
            chk("sb_msg", rd_msg, e.msg);
`ifdef RPT_TIMESTAMP_EN
            chk("sb_time", rd_time, e.ts);
`endif
        end
        g = -1;
        for (int i = 0; i < NCH; i++) begin
            c = (m_ptr + i) % NCH;
            if (!m_exit && g < 0 && ev_valid[c]) g = c;
        end
        eg = (g >= 0) ? (4'b0001 << g) : 4'b0000;
        chk("ev_ready", ev_ready, eg);
        if (clr_i) begin
            for (int k = 0; k < 4; k++) m_cnt[k] = 0;
            m_drop = 0;
            m_stop = 1'b0;
            m_exit = 1'b0;
        end
        if (g >= 0) begin
            t = ev_type[2*g +: 2];
            s = ev_sev[2*g +: 2];
            a = ev_act[2*g +: 2];
            if (m_cnt[t] < CMAX) m_cnt[t]++;
            if (s >= svrt_i) begin
                if (sb.size() < DEPTH) begin
                    e.typ = t;
                    e.src = 2'(g);
                    e.msg = ev_msg[16*g +: 16];
                    e.ts  = tb_cyc;
                    sb.push_back(e);
                end else if (m_drop < CMAX) begin
                    m_drop++;
                end
                if (a == 2'd1) m_stop = 1'b1;
                if (a == 2'd2) m_exit = 1'b1;
            end
            m_ptr = (g + 1) % NCH;
        end
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic set_ch(input int ch, input logic [1:0] t, input logic [1:0] s,
                          input logic [1:0] a, input logic [15:0] m);
        ev_type[2*ch +: 2] = t;
        ev_sev[2*ch +: 2]  = s;
        ev_act[2*ch +: 2]  = a;
        ev_msg[16*ch +: 16] = m;
    endtask

    task automatic send(input int ch, input logic [1:0] t, input logic [1:0] s,
                        input logic [1:0] a, input logic [15:0] m);
        set_ch(ch, t, s, a, m);
        ev_valid     = '0;
        ev_valid[ch] = 1'b1;
        step();
        ev_valid = '0;
    endtask

    task automatic drain();
        rd_ready = 1'b1;
        for (int k = 0; k < 2*DEPTH && sb.size() != 0; k++) step();
        chk("drain_empty", rd_valid, 1'b0);
    endtask

    task automatic clear_step();
        clr_i = 1'b1;
        step();
        clr_i = 1'b0;
    endtask

    initial begin
        n_pass = 0; n_total = 0; n_fail = 0;
        rstn = 1'b0; ev_valid = '0; ev_type = '0; ev_sev = '0; ev_act = '0; ev_msg = '0;
        svrt_i = 2'd0; clr_i = 1'b0; rd_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rstn = 1'b1;

        // Single ERROR/HIGH/LOG from channel 2, one-cycle record latency.
        svrt_i = 2'd1;
        send(2, 2'd2, 2'd2, 2'd0, 16'hBEEF);
        chk("t1_cnt_err", cnt_err, 4'd1);
        chk("t1_rd_valid", rd_valid, 1'b1);
        chk("t1_rd_src", rd_src, 2'd2);
        chk("t1_rd_msg", rd_msg, 16'hBEEF);
        rd_ready = 1'b1;
        step();

        // All channels requesting: round-robin, one accept per cycle.
        clear_step();
        for (int i = 0; i < NCH; i++) set_ch(i, 2'(i), 2'd2, 2'd0, 16'(16'hA000 + i));
        ev_valid = 4'hF;
        repeat (8) step();
        ev_valid = '0;
        chk("rr_info", cnt_info, 4'd2);
        chk("rr_warn", cnt_warn, 4'd2);
        chk("rr_err", cnt_err, 4'd2);
        chk("rr_fatal", cnt_fatal, 4'd2);
        drain();

        // Below-threshold events are only counted.
        clear_step();
        svrt_i = 2'd2;
        for (int k = 0; k < 5; k++) send(0, 2'd0, 2'd0, 2'd0, 16'(16'h1100 + k));
        chk("flt_info", cnt_info, 4'd5);
        chk("flt_empty", rd_valid, 1'b0);
        chk("flt_drop", drop_cnt, 4'd0);

        // Overfill with reader stalled, then push and pop on a full FIFO.
        svrt_i = 2'd0;
        rd_ready = 1'b0;
        for (int k = 0; k < 10; k++) send(1, 2'd1, 2'd0, 2'd0, 16'(16'h2000 + k));
        chk("ovf_drop", drop_cnt, 4'd2);
        chk("ovf_valid", rd_valid, 1'b1);
        rd_ready = 1'b1;
        send(3, 2'd3, 2'd1, 2'd0, 16'h3333);
        chk("full_pp_drop", drop_cnt, 4'd2);
        drain();

        // STOP: filtered out below threshold, latched at TOP severity.
        svrt_i = 2'd3;
        send(0, 2'd1, 2'd0, 2'd1, 16'h5100);
        chk("stop_filtered", stop_o, 1'b0);
        send(0, 2'd1, 2'd3, 2'd1, 16'h5101);
        chk("stop_set", stop_o, 1'b1);
        send(2, 2'd0, 2'd3, 2'd3, 16'h5102);

        // EXIT blocks acceptance until clr_i.
        svrt_i = 2'd0;
        send(1, 2'd2, 2'd2, 2'd2, 16'hE1E1);
        chk("exit_set", exit_o, 1'b1);
        for (int i = 0; i < NCH; i++) set_ch(i, 2'd0, 2'd1, 2'd0, 16'(16'hC000 + i));
        ev_valid = 4'hF;
        step();
        chk("exit_block", ev_ready, 4'h0);
        clear_step();
        chk("exit_clr", exit_o, 1'b0);
        chk("stop_clr", stop_o, 1'b0);
        step();
        ev_valid = '0;
        clr_i = 1'b1;
        send(1, 2'd1, 2'd1, 2'd0, 16'h7777);
        clr_i = 1'b0;
        chk("clr_acc_warn", cnt_warn, 4'd1);
        drain();

        // Counter saturation.
        clear_step();
        svrt_i = 2'd3;
        for (int k = 0; k < 17; k++) send(2, 2'd1, 2'd0, 2'd0, 16'h0);
        chk("warn_sat", cnt_warn, 4'hF);

        // Asynchronous reset with records pending.
        svrt_i = 2'd0;
        rd_ready = 1'b0;
        for (int k = 0; k < 3; k++) send(k, 2'd3, 2'd0, 2'd0, 16'(16'h9000 + k));
        chk("pre_rst_valid", rd_valid, 1'b1);
        #2 rstn = 1'b0;
        #1;
        model_reset();
        chk("arst_valid", rd_valid, 1'b0);
        chk("arst_fatal", cnt_fatal, 4'd0);
        #1 rstn = 1'b1;
        @(negedge clk);
        check_all();

        // Post-reset records at different cycles (timestamps checked when built).
        rd_ready = 1'b1;
        repeat (3) step();
        send(3, 2'd2, 2'd1, 2'd0, 16'h0005);
        repeat (3) step();
        send(0, 2'd0, 2'd1, 2'd0, 16'h0009);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
